// File: rtl/mp_addsub_seq.sv
// Limb-serial multi-precision adder/subtractor with conditional subtract (A-B if A>=B, else A).
// One LIMB_W slice is added per clock; operands shift right as limbs are consumed.
module mp_addsub_seq #(
   parameter int WIDTH  = 1027,
   parameter int LIMB_W = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic [WIDTH:0]   result,
   output logic             busy,
   output logic             done
);
   localparam int NLIMBS = (WIDTH + LIMB_W - 1) / LIMB_W;
   localparam int PAD_W  = NLIMBS * LIMB_W;
   localparam int KW     = (NLIMBS > 1) ? $clog2(NLIMBS) : 1;
   localparam bit PADDED = (PAD_W > WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state_reg;
   logic [PAD_W-1:0]   a_reg, b_reg, a_next, b_next;
   logic [WIDTH-1:0]   a_keep_reg;
   logic [1:0]         op_reg;
   logic               carry_reg;
   logic [KW-1:0]      k_reg;
   logic [LIMB_W:0]    limb_sum;
   logic [PAD_W:0]     full_sum;
   logic [WIDTH:0]     result_next;
   logic               last_limb;
   logic               borrow;
   logic               start_sub;

   assign limb_sum  = {1'b0, a_reg[LIMB_W-1:0]} + {1'b0, b_reg[LIMB_W-1:0]}
                    + {{LIMB_W{1'b0}}, carry_reg};
   assign last_limb = (k_reg == KW'(NLIMBS - 1));
   assign start_sub = (op == 2'b01) || (op == 2'b10);

   // full_sum carries the final carry-out just above the padded sum, so bit WIDTH
   // is either the real sum bit (padded case) or the carry-out (exact fit).
   generate
      if (NLIMBS > 1) begin : g_multi
         logic [PAD_W-LIMB_W-1:0] sum_reg;

         always_ff @(posedge clk) begin
            if (state_reg == RUN && !last_limb)
               sum_reg[k_reg*LIMB_W +: LIMB_W] <= limb_sum[LIMB_W-1:0];
         end

         assign full_sum = {limb_sum, sum_reg};
         assign a_next   = {{LIMB_W{1'b0}}, a_reg[PAD_W-1:LIMB_W]};
         assign b_next   = {{LIMB_W{1'b0}}, b_reg[PAD_W-1:LIMB_W]};
      end else begin : g_single
         assign full_sum = limb_sum;
         assign a_next   = a_reg;
         assign b_next   = b_reg;
      end

      if (PAD_W > WIDTH) begin : g_pad
         logic unused_pad;
         assign unused_pad = ^full_sum[PAD_W:WIDTH+1];
      end
   endgenerate

   // With padding, the inverted-B padding bits make bit WIDTH a sign bit;
   // without padding, a borrow shows up as a missing carry-out.
   assign borrow = PADDED ? full_sum[WIDTH] : ~full_sum[WIDTH];

   always_comb begin
      result_next = full_sum[WIDTH:0];
      if (op_reg == 2'b01)
         result_next = {borrow, full_sum[WIDTH-1:0]};
      else if (op_reg == 2'b10)
         result_next = borrow ? {1'b0, a_keep_reg} : {1'b0, full_sum[WIDTH-1:0]};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         result    <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         k_reg     <= '0;
         carry_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  a_reg      <= PAD_W'(in_a);
                  a_keep_reg <= in_a;
                  op_reg     <= op;
                  b_reg      <= start_sub ? ~PAD_W'(in_b) : PAD_W'(in_b);
                  carry_reg  <= start_sub;
                  k_reg      <= '0;
                  busy       <= 1'b1;
                  state_reg  <= RUN;
               end
            end
            RUN: begin
               a_reg     <= a_next;
               b_reg     <= b_next;
               carry_reg <= limb_sum[LIMB_W];
               k_reg     <= k_reg + 1'b1;
               if (last_limb) begin
                  result    <= result_next;
                  done      <= 1'b1;
                  k_reg     <= '0;
                  state_reg <= DONE;
               end
            end
            DONE: begin
               done      <= 1'b0;
               busy      <= 1'b0;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mp_addsub_seq.sv
// Directed bench for mp_addsub_seq at default parameters (WIDTH=1027, LIMB_W=64, 17 limbs).
// Cycle n is the interval after posedge n; done is expected 18 cycles after the start cycle.
module tb_mp_addsub_seq;
   localparam int W = 1027;
   localparam int R = W + 1;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [1:0]   op;
   logic [W-1:0] in_a, in_b;
   logic [W:0]   result;
   logic         busy, done;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   mp_addsub_seq #(.WIDTH(W), .LIMB_W(64)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .in_a   (in_a),
      .in_b   (in_b),
      .result (result),
      .busy   (busy),
      .done   (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [W-1:0] sa(input int v);
      return W'(v);
   endfunction

   function automatic logic [W:0] sr(input int v);
      return R'(v);
   endfunction

   task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed lo=%0h top=%0h, expected lo=%0h top=%0h",
                tag, obs[127:0], obs[W:W-63], exp[127:0], exp[W:W-63]);
      end
   endtask

   task automatic do_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W:0] exp);
      int c0;
      logic seen;
      logic [W:0] prev;
      prev = result;
      @(negedge clk);
      op = o; in_a = a; in_b = b; start = 1'b1;
      c0 = cyc;
      @(negedge clk);
      start = 1'b0; in_a = ~a; in_b = ~b; op = 2'b11;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(posedge clk); #1;
         if (done) seen = 1'b1;
         else if (i == 8) begin
            check({tag, " held"}, result, prev);
            check({tag, " busy_run"}, R'(busy), sr(1));
         end
      end
      check({tag, " done_seen"}, R'(seen), sr(1));
      check({tag, " latency"}, R'(cyc - c0), sr(18));
      check({tag, " result"}, result, exp);
      check({tag, " busy_done"}, R'(busy), sr(1));
      @(posedge clk); #1;
      check({tag, " done_drop"}, R'(done), sr(0));
      check({tag, " busy_drop"}, R'(busy), sr(0));
   endtask

   initial begin
      logic [W-1:0] a_pat, b_pat, a_half;
      logic [W:0]   e_pat, prev;
      int c0, npulse, ndone;
      logic seen;

      reset = 1'b1; start = 1'b0; op = 2'b00; in_a = '0; in_b = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset result", result, sr(0));
      check("reset busy", R'(busy), sr(0));
      check("reset done", R'(done), sr(0));
      @(negedge clk);
      reset = 1'b0;

      a_half = sa(1) << (W - 1);
      a_pat  = '0; a_pat[255:192] = '1;
      b_pat  = '0; b_pat[192] = 1'b1;
      e_pat  = '0; e_pat[256] = 1'b1;

      do_op("add_carry_chain", 2'b00, '1, sa(1), {1'b1, {W{1'b0}}});
      do_op("sub_5_7", 2'b01, sa(5), sa(7), {{W{1'b1}}, 1'b0});
      do_op("csub_7_5", 2'b10, sa(7), sa(5), sr(2));
      do_op("csub_5_7", 2'b10, sa(5), sa(7), sr(5));
      do_op("csub_equal", 2'b10, a_half, a_half, sr(0));
      do_op("sub_7_5", 2'b01, sa(7), sa(5), sr(2));
      do_op("sub_0_1", 2'b01, sa(0), sa(1), {R{1'b1}});
      do_op("add_reserved", 2'b11, sa(3), sa(4), sr(7));
      do_op("add_top_bits", 2'b00, a_half, a_half, {1'b1, {W{1'b0}}});
      do_op("csub_max_1", 2'b10, '1, sa(1), {1'b0, {(W-1){1'b1}}, 1'b0});
      do_op("add_mid_limb", 2'b00, a_pat, b_pat, e_pat);

      // Abort mid-operation: reset during RUN limb 8.
      @(negedge clk);
      op = 2'b00; in_a = '1; in_b = sa(1); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      check("abort result", result, sr(0));
      check("abort busy", R'(busy), sr(0));
      check("abort done", R'(done), sr(0));
      @(negedge clk);
      reset = 1'b0;
      ndone = 0;
      for (int i = 0; i < 25; i++) begin
         @(posedge clk); #1;
         if (done) ndone++;
      end
      check("abort no_done", R'(ndone), sr(0));
      do_op("after_abort", 2'b00, sa(9), sa(6), sr(15));

      // start held for 40 cycles: accepts only in IDLE, one op per 19 cycles.
      @(negedge clk);
      op = 2'b00; in_a = sa(1); in_b = sa(1); start = 1'b1;
      c0 = cyc;
      npulse = 0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (done) begin
            npulse++;
            check("hold pulse_cycle", R'(cyc - c0), (npulse == 1) ? sr(18) : sr(37));
            check("hold result", result, sr(2));
         end
         if (i == 19) check("hold idle_gap", R'(busy), sr(0));
         if (i == 20) check("hold reaccept", R'(busy), sr(1));
      end
      check("hold pulse_count", R'(npulse), sr(2));
      @(negedge clk);
      start = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(posedge clk); #1;
         if (done) seen = 1'b1;
      end
      check("hold third_cycle", R'(cyc - c0), sr(56));
      check("hold third_result", result, sr(2));
      prev = result;
      repeat (2) @(posedge clk);
      #1;
      check("final idle", R'(busy), sr(0));
      check("final held", result, prev);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
